// File: rtl/rng_avmm_pkg.sv
// Shared types and constants for the Avalon-MM result reader.
// State encoding and the fixed command/word addressing constants.
package rng_avmm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD_WR,
    RD_REQ,
    RD_WAIT,
    OUT,
    DONE
  } state_t;

  localparam int unsigned WORD_SHIFT = 3;
  localparam int unsigned CMD_ADDR   = 0;

endpackage

// File: rtl/avmm_out_reg.sv
// Output holding register for the result stream.
// Data, index and last stay frozen until the consumer accepts the word.
module avmm_out_reg #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [IDX_W-1:0]  load_index,
  input  logic              load_last,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_valid,
  output logic              out_last,
  output logic              fire
);

  assign fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_index <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_index <= load_index;
      out_last  <= load_last;
      out_valid <= 1'b1;
    end else if (fire) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/avmm_result_reader.sv
// Avalon-MM master: writes one command word, then reads NUM_WORDS result
// words one at a time and presents each on a valid/ready stream.
module avmm_result_reader
  import rng_avmm_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned NUM_WORDS = 66,
  parameter int unsigned IDX_W     = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   cmd_word,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   master_address,
  output logic                master_read,
  output logic                master_write,
  output logic [DATA_W-1:0]   master_writedata,
  output logic [DATA_W/8-1:0] master_byteenable,
  input  logic                master_waitrequest,
  input  logic [DATA_W-1:0]   master_readdata,
  input  logic                master_readdatavalid,
  output logic [DATA_W-1:0]   out_data,
  output logic [IDX_W-1:0]    out_index,
  output logic                out_valid,
  output logic                out_last,
  input  logic                out_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t                state, state_d;
  logic [IDX_W-1:0]      idx, idx_d;
  logic                  busy_d, done_d;
  logic                  read_d, write_d;
  logic [ADDR_W-1:0]     addr_d;
  logic [DATA_W-1:0]     wdata_d;
  logic [DATA_W/8-1:0]   be_d;
  logic                  load, fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      idx               <= '0;
      busy              <= 1'b0;
      done              <= 1'b0;
      master_read       <= 1'b0;
      master_write      <= 1'b0;
      master_address    <= '0;
      master_writedata  <= '0;
      master_byteenable <= '0;
    end else begin
      state             <= state_d;
      idx               <= idx_d;
      busy              <= busy_d;
      done              <= done_d;
      master_read       <= read_d;
      master_write      <= write_d;
      master_address    <= addr_d;
      master_writedata  <= wdata_d;
      master_byteenable <= be_d;
    end
  end

  // Request strobes rise one cycle after entering CMD_WR/RD_REQ and are
  // dropped on the acceptance edge, so the bus outputs stay registered.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    busy_d  = busy;
    done_d  = 1'b0;
    read_d  = master_read;
    write_d = master_write;
    addr_d  = master_address;
    wdata_d = master_writedata;
    be_d    = master_byteenable;
    load    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          wdata_d = cmd_word;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = CMD_WR;
        end
      end
      CMD_WR: begin
        if (!master_write) begin
          write_d = 1'b1;
          be_d    = '1;
          addr_d  = ADDR_W'(CMD_ADDR);
        end else if (!master_waitrequest) begin
          write_d = 1'b0;
          be_d    = '0;
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (!master_read) begin
          read_d = 1'b1;
          be_d   = '1;
          addr_d = ADDR_W'(idx) << WORD_SHIFT;
        end else if (!master_waitrequest) begin
          read_d  = 1'b0;
          be_d    = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (master_readdatavalid) begin
          load    = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (fire) begin
          if (out_last) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = DONE;
          end else begin
            idx_d   = idx + 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  avmm_out_reg #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (master_readdata),
    .load_index (idx),
    .load_last  (idx == LAST_IDX),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_index  (out_index),
    .out_valid  (out_valid),
    .out_last   (out_last),
    .fire       (fire)
  );

endmodule

// File: tb/tb_avmm_result_reader.sv
// Directed bench for avmm_result_reader with a small Avalon-MM slave model
// (programmable waitrequest stalls and read latency) and a stream monitor.
module tb_avmm_result_reader;

  localparam int unsigned NW = 66;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] cmd_word;
  logic        busy, done;
  logic [9:0]  master_address;
  logic        master_read, master_write;
  logic [63:0] master_writedata;
  logic [7:0]  master_byteenable;
  logic        master_waitrequest;
  logic [63:0] master_readdata;
  logic        master_readdatavalid;
  logic [63:0] out_data;
  logic [6:0]  out_index;
  logic        out_valid, out_last;
  logic        out_ready;

  int n_checks = 0;
  int n_err    = 0;

  // slave configuration
  logic [3:0]  wr_stall;
  logic [3:0]  rd_stall;
  logic [9:0]  rd_stall_addr;
  int          rdv_lat_idx;
  int          rdv_lat;
  logic        rand_ready;

  // monitor counters
  int          wr_count, rd_count, word_count, done_count;
  logic [63:0] exp_cmd;

  always #5 clk = ~clk;

  avmm_result_reader #(
    .ADDR_W    (10),
    .DATA_W    (64),
    .NUM_WORDS (66),
    .IDX_W     (7)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .start                (start),
    .cmd_word             (cmd_word),
    .busy                 (busy),
    .done                 (done),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_write         (master_write),
    .master_writedata     (master_writedata),
    .master_byteenable    (master_byteenable),
    .master_waitrequest   (master_waitrequest),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .out_data             (out_data),
    .out_index            (out_index),
    .out_valid            (out_valid),
    .out_last             (out_last),
    .out_ready            (out_ready)
  );

  function automatic logic [63:0] word(input int unsigned i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  function automatic int lat_for(input int i);
    return (i == rdv_lat_idx) ? rdv_lat : 1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // ---------------- slave model ----------------
  logic [3:0] waited;
  logic       pend;
  int         pcnt;
  int         pword;

  assign master_waitrequest =
      (master_write && (waited < wr_stall)) ||
      (master_read && (master_address == rd_stall_addr) && (waited < rd_stall));

  always @(posedge clk) begin
    if ((master_read || master_write) && master_waitrequest) waited <= waited + 4'd1;
    else waited <= 4'd0;
  end

  always @(posedge clk) begin
    master_readdatavalid <= 1'b0;
    if (pend) begin
      if (pcnt == 1) begin
        master_readdatavalid <= 1'b1;
        master_readdata      <= word(pword);
        pend                 <= 1'b0;
      end else begin
        pcnt <= pcnt - 1;
      end
    end
    if (master_read && !master_waitrequest) begin
      if (lat_for(int'(master_address >> 3)) <= 1) begin
        master_readdatavalid <= 1'b1;
        master_readdata      <= word(int'(master_address >> 3));
      end else begin
        pend  <= 1'b1;
        pcnt  <= lat_for(int'(master_address >> 3)) - 1;
        pword <= int'(master_address >> 3);
      end
    end
  end

  // ---------------- negedge monitor ----------------
  logic        prev_stall, prev_hold, prev_rd_acc;
  logic [9:0]  p_addr;
  logic        p_rd, p_wr;
  logic [63:0] p_wdata;
  logic [7:0]  p_be;
  logic [63:0] h_data;
  logic [6:0]  h_index;
  logic        h_last;

  always @(negedge clk) begin
    if (reset) begin
      prev_stall  = 1'b0;
      prev_hold   = 1'b0;
      prev_rd_acc = 1'b0;
    end else begin
      out_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
      if (prev_stall) begin
        check("stall_addr", 64'(master_address), 64'(p_addr));
        check("stall_read", 64'(master_read), 64'(p_rd));
        check("stall_write", 64'(master_write), 64'(p_wr));
        check("stall_wdata", master_writedata, p_wdata);
        check("stall_be", 64'(master_byteenable), 64'(p_be));
      end
      if (prev_rd_acc) check("rd_drop", 64'(master_read), 64'd0);
      if (master_read || master_write) begin
        check("rw_excl", 64'(master_read & master_write), 64'd0);
        check("be_on", 64'(master_byteenable), 64'hFF);
      end
      if (out_valid) check("no_rd_while_valid", 64'(master_read), 64'd0);
      if (prev_hold) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_data", out_data, h_data);
        check("hold_index", 64'(out_index), 64'(h_index));
        check("hold_last", 64'(out_last), 64'(h_last));
      end
      if (master_write && !master_waitrequest) begin
        check("wr_addr", 64'(master_address), 64'd0);
        check("wr_data", master_writedata, exp_cmd);
        wr_count++;
      end
      if (master_read && !master_waitrequest) begin
        check("rd_addr", 64'(master_address), 64'(rd_count * 8));
        rd_count++;
      end
      if (out_valid && out_ready) begin
        check("out_data", out_data, word(word_count));
        check("out_index", 64'(out_index), 64'(word_count));
        check("out_last", 64'(out_last), 64'(word_count == NW - 1));
        word_count++;
      end
      if (done) begin
        check("done_words", 64'(word_count), 64'(NW));
        done_count++;
      end
      prev_stall  = (master_read || master_write) && master_waitrequest;
      p_addr      = master_address;
      p_rd        = master_read;
      p_wr        = master_write;
      p_wdata     = master_writedata;
      p_be        = master_byteenable;
      prev_hold   = out_valid && !out_ready;
      h_data      = out_data;
      h_index     = out_index;
      h_last      = out_last;
      prev_rd_acc = master_read && !master_waitrequest;
    end
  end

  // ---------------- helpers ----------------
  task automatic clear_counts(input logic [63:0] cmd);
    wr_count   = 0;
    rd_count   = 0;
    word_count = 0;
    done_count = 0;
    exp_cmd    = cmd;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_addr"}, 64'(master_address), 64'd0);
    check({tag, "_read"}, 64'(master_read), 64'd0);
    check({tag, "_write"}, 64'(master_write), 64'd0);
    check({tag, "_wdata"}, master_writedata, 64'd0);
    check({tag, "_be"}, 64'(master_byteenable), 64'd0);
    check({tag, "_odata"}, out_data, 64'd0);
    check({tag, "_oidx"}, 64'(out_index), 64'd0);
    check({tag, "_ovalid"}, 64'(out_valid), 64'd0);
    check({tag, "_olast"}, 64'(out_last), 64'd0);
  endtask

  // Start a run and wait for done. extra_at: cycle for a stray start while
  // busy (0 = none); on_done: also pulse start in the done cycle.
  task automatic run(input logic [63:0] cmd, input int limit, input int extra_at,
                     input logic on_done, output int cyc);
    clear_counts(cmd);
    @(negedge clk);
    start    = 1'b1;
    cmd_word = cmd;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!done && cyc < limit) begin
      @(negedge clk);
      cyc++;
      start = (cyc == extra_at);
      if (start) cmd_word = ~cmd;
    end
    start = 1'b0;
    check("done_seen", 64'(done), 64'd1);
    if (on_done) begin
      start    = 1'b1;
      cmd_word = ~cmd;
      @(negedge clk);
      start = 1'b0;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_run(input string tag);
    check({tag, "_writes"}, 64'(wr_count), 64'd1);
    check({tag, "_reads"}, 64'(rd_count), 64'(NW));
    check({tag, "_words"}, 64'(word_count), 64'(NW));
    check({tag, "_dones"}, 64'(done_count), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cyc;
    reset         = 1'b1;
    start         = 1'b0;
    cmd_word      = '0;
    out_ready     = 1'b1;
    wr_stall      = 4'd0;
    rd_stall      = 4'd0;
    rd_stall_addr = 10'd0;
    rdv_lat_idx   = -1;
    rdv_lat       = 1;
    rand_ready    = 1'b0;
    pend          = 1'b0;
    master_readdata = '0;
    clear_counts(64'd0);
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // zero-wait, 1-cycle latency
    run(64'h1, 1000, 0, 1'b0, cyc);
    check("basic_cycles", 64'(cyc), 64'd267);
    check_run("basic");

    // 3-cycle stalls on the command write and on the read of index 10
    wr_stall      = 4'd3;
    rd_stall      = 4'd3;
    rd_stall_addr = 10'd80;
    run(64'h0123_4567_89AB_CDEF, 1000, 0, 1'b0, cyc);
    check("stall_cycles", 64'(cyc), 64'd273);
    check_run("stall");
    wr_stall = 4'd0;
    rd_stall = 4'd0;

    // random out_ready at 30 %
    rand_ready = 1'b1;
    run(64'h55, 5000, 0, 1'b0, cyc);
    check_run("rand");
    rand_ready = 1'b0;
    @(negedge clk);

    // readdatavalid 5 cycles late on index 0
    rdv_lat_idx = 0;
    rdv_lat     = 5;
    run(64'h77, 1000, 0, 1'b0, cyc);
    check("lat_cycles", 64'(cyc), 64'd271);
    check_run("lat");

    // reset during RD_WAIT at index 20, stale readdatavalid afterwards
    rdv_lat_idx = 20;
    rdv_lat     = 2;
    clear_counts(64'h99);
    @(negedge clk);
    start    = 1'b1;
    cmd_word = 64'h99;
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (!(master_read && !master_waitrequest && master_address == 10'd160) && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    check("rd20_seen", 64'(master_address), 64'd160);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_zero_outputs("midreset");
    check("stale_rdv_present", 64'(master_readdatavalid), 64'd1);
    repeat (5) begin
      @(negedge clk);
      check("post_reset_valid", 64'(out_valid), 64'd0);
      check("post_reset_done", 64'(done), 64'd0);
      check("post_reset_busy", 64'(busy), 64'd0);
    end
    rdv_lat_idx = -1;
    rdv_lat     = 1;
    run(64'h1, 1000, 0, 1'b0, cyc);
    check("rerun_cycles", 64'(cyc), 64'd267);
    check_run("rerun");

    // start while busy and in the done cycle are both ignored
    run(64'h2, 1000, 50, 1'b1, cyc);
    check("ignore_cycles", 64'(cyc), 64'd267);
    check_run("ignore");
    repeat (4) @(negedge clk);
    check("ignore_no_write", 64'(wr_count), 64'd1);
    check("ignore_idle_write", 64'(master_write), 64'd0);
    check("ignore_idle_busy", 64'(busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
